exc_commit_unit: RTL and testbench

//  Commit-stage exception producer for the dual-issue pipeline; drives the CP0 exception-request inputs.

---
 rtl/exc_commit_unit_pkg.sv | 73 +++++++
 rtl/exc_commit_unit_int_sync.sv | 26 ++
 rtl/exc_commit_unit.sv | 130 +++++++++++++
 tb/tb_exc_commit_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_commit_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exc_commit_unit_pkg : exception codes, CP0 field indices, per-slot picker
// Revision: 1.0
// ---------------------------------------------------------------------------
package exc_commit_unit_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_AdEL = 5'h04;
  localparam logic [4:0] EXC_AdES = 5'h05;
  localparam logic [4:0] EXC_Sys  = 5'h08;
  localparam logic [4:0] EXC_Bp   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_Ov   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;
  localparam logic [4:0] EXC_NONE = 5'h1f;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_IM_LO = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 8;

  localparam int F_ADEL_IF  = 0;
  localparam int F_RI       = 1;
  localparam int F_SYS      = 2;
  localparam int F_BP       = 3;
  localparam int F_OV       = 4;
  localparam int F_ADEL_MEM = 5;
  localparam int F_ADES     = 6;
  localparam int F_ERET     = 7;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic        hit;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] badaddr;
  } slot_evt_t;

  function automatic slot_evt_t slot_pick(
    input logic        valid,
    input logic        int_here,
    input logic [7:0]  exc,
    input logic [31:0] pc,
    input logic [31:0] maddr
  );
    slot_evt_t e;
    e.hit     = valid & (int_here | (|exc));
    e.eret    = 1'b0;
    e.code    = EXC_NONE;
    e.badaddr = 32'd0;
    if (valid) begin
      if (int_here)               e.code = EXC_INT;
      else if (exc[F_ADEL_IF])  begin e.code = EXC_AdEL; e.badaddr = pc;    end
      else if (exc[F_RI])         e.code = EXC_RI;
      else if (exc[F_SYS])        e.code = EXC_Sys;
      else if (exc[F_BP])         e.code = EXC_Bp;
      else if (exc[F_OV])         e.code = EXC_Ov;
      else if (exc[F_ADEL_MEM]) begin e.code = EXC_AdEL; e.badaddr = maddr; end
      else if (exc[F_ADES])     begin e.code = EXC_AdES; e.badaddr = maddr; end
      else if (exc[F_ERET])     begin e.code = EXC_ERET; e.eret = 1'b1;    end
    end
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exc_commit_unit_int_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exc_commit_unit_int_sync : reset-to-0 synchroniser chain for interrupt lines
// Revision: 1.0
// ---------------------------------------------------------------------------
module exc_commit_unit_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_sync <= '0;
    else         r_sync <= {r_sync[STAGES-2:0], din_i};
  end

  assign dout_o = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/exc_commit_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exc_commit_unit : commit-stage exception arbiter, CP0 request driver, drain FSM
// Revision: 1.0
// ---------------------------------------------------------------------------
module exc_commit_unit
  import exc_commit_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_i,
  input  logic        s0_valid_i,
  input  logic [31:0] s0_pc_i,
  input  logic [7:0]  s0_exc_i,
  input  logic        s0_delay_i,
  input  logic [31:0] s0_maddr_i,
  input  logic        s1_valid_i,
  input  logic [31:0] s1_pc_i,
  input  logic [7:0]  s1_exc_i,
  input  logic        s1_delay_i,
  input  logic [31:0] s1_maddr_i,
  input  logic [5:0]  ext_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic        redirect_ack_i,
  output logic [4:0]  exccode_o,
  output logic [31:0] pc_o,
  output logic [31:0] badaddr_o,
  output logic        in_delay_o,
  output logic        s0_kill_o,
  output logic        s1_kill_o,
  output logic [5:0]  ip_hw_o,
  output logic        busy_o
);

  localparam int             CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ack, w_ack_nxt;

  logic      w_int_pend;
  logic      w_take;
  logic      w_sel0;
  slot_evt_t w_ev0, w_ev1, w_sel;
  logic      w_unused;

  exc_commit_unit_int_sync #(
    .WIDTH  (6),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk    (clk),
    .resetn (resetn),
    .din_i  (ext_int_i),
    .dout_o (ip_hw_o)
  );

  assign w_int_pend = status_i[STATUS_IE] & ~status_i[STATUS_EXL] &
                      (|(cause_i[CAUSE_IP_HI:CAUSE_IP_LO] & status_i[STATUS_IM_HI:STATUS_IM_LO]));

  // The interrupt rides on the oldest valid instruction only.
  assign w_ev0 = slot_pick(s0_valid_i, s0_valid_i & w_int_pend, s0_exc_i, s0_pc_i, s0_maddr_i);
  assign w_ev1 = slot_pick(s1_valid_i, ~s0_valid_i & s1_valid_i & w_int_pend,
                           s1_exc_i, s1_pc_i, s1_maddr_i);

  assign w_sel0 = w_ev0.hit;
  assign w_sel  = w_sel0 ? w_ev0 : w_ev1;
  assign w_take = resetn & ~stall_i & (r_state == ST_RUN) & (w_ev0.hit | w_ev1.hit);

  assign w_unused = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = r_ack;
    exccode_o   = EXC_NONE;
    pc_o        = 32'd0;
    badaddr_o   = 32'd0;
    in_delay_o  = 1'b0;
    s0_kill_o   = 1'b0;
    s1_kill_o   = 1'b0;
    busy_o      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_take) begin
          exccode_o   = w_sel.code;
          pc_o        = w_sel0 ? s0_pc_i : s1_pc_i;
          badaddr_o   = w_sel.badaddr;
          in_delay_o  = w_sel0 ? s0_delay_i : s1_delay_i;
          // ERET flushes younger work but lets its own slot retire.
          s0_kill_o   = w_sel0 & ~w_sel.eret;
          s1_kill_o   = w_sel0 | ~w_sel.eret;
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = CNT_INIT;
          w_ack_nxt   = 1'b0;
        end
      end
      ST_DRAIN: begin
        busy_o    = 1'b1;
        s0_kill_o = 1'b1;
        s1_kill_o = 1'b1;
        if ((r_cnt == '0) && (r_ack | redirect_ack_i)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_ack_nxt = r_ack | redirect_ack_i;
          if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_exc_commit_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_exc_commit_unit : directed + randomized bench with a priority-list model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_exc_commit_unit;

  localparam int D = 2;
  localparam int S = 2;
  localparam logic [4:0] NONE = 5'h1f;

  logic        clk = 1'b0;
  logic        resetn, stall_i, redirect_ack_i;
  logic        s0_valid_i, s0_delay_i, s1_valid_i, s1_delay_i;
  logic [31:0] s0_pc_i, s0_maddr_i, s1_pc_i, s1_maddr_i, status_i, cause_i;
  logic [7:0]  s0_exc_i, s1_exc_i;
  logic [5:0]  ext_int_i;
  logic [4:0]  exccode_o;
  logic [31:0] pc_o, badaddr_o;
  logic        in_delay_o, s0_kill_o, s1_kill_o, busy_o;
  logic [5:0]  ip_hw_o;

  int checks = 0;
  int failures = 0;

  bit         m_busy;
  int         m_age;
  bit         m_ack;
  logic [5:0] m_sh [S];

  exc_commit_unit #(.DRAIN_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .resetn(resetn), .stall_i(stall_i),
    .s0_valid_i(s0_valid_i), .s0_pc_i(s0_pc_i), .s0_exc_i(s0_exc_i),
    .s0_delay_i(s0_delay_i), .s0_maddr_i(s0_maddr_i),
    .s1_valid_i(s1_valid_i), .s1_pc_i(s1_pc_i), .s1_exc_i(s1_exc_i),
    .s1_delay_i(s1_delay_i), .s1_maddr_i(s1_maddr_i),
    .ext_int_i(ext_int_i), .status_i(status_i), .cause_i(cause_i),
    .redirect_ack_i(redirect_ack_i),
    .exccode_o(exccode_o), .pc_o(pc_o), .badaddr_o(badaddr_o),
    .in_delay_o(in_delay_o), .s0_kill_o(s0_kill_o), .s1_kill_o(s1_kill_o),
    .ip_hw_o(ip_hw_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Priority list index: 0 INT, 1 AdEL-fetch, 2 RI, 3 Sys, 4 Bp, 5 Ov, 6 AdEL-mem, 7 AdES, 8 ERET
  function automatic logic [4:0] code_of(input int idx);
    case (idx)
      0: return 5'h00;
      1: return 5'h04;
      2: return 5'h0a;
      3: return 5'h08;
      4: return 5'h09;
      5: return 5'h0c;
      6: return 5'h04;
      7: return 5'h05;
      default: return 5'h0e;
    endcase
  endfunction

  function automatic void expect_out(output logic [4:0] code, output logic [31:0] pc,
                                     output logic [31:0] ba, output logic dly, output logic k0,
                                     output logic k1, output logic busy, output logic taken);
    logic       ip;
    logic [8:0] v0, v1, v;
    logic       slot0;
    int         idx;
    code = NONE; pc = 0; ba = 0; dly = 0; k0 = 0; k1 = 0; busy = 0; taken = 0;
    if (!resetn) return;
    if (m_busy) begin k0 = 1; k1 = 1; busy = 1; return; end
    if (stall_i) return;
    ip = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
    v0 = s0_valid_i ? {s0_exc_i, ip} : 9'd0;
    v1 = s1_valid_i ? {s1_exc_i, ip & ~s0_valid_i} : 9'd0;
    if (v0 == 0 && v1 == 0) return;
    slot0 = (v0 != 0);
    v = slot0 ? v0 : v1;
    idx = 8;
    for (int i = 8; i >= 0; i--) if (v[i]) idx = i;
    taken = 1;
    code = code_of(idx);
    pc = slot0 ? s0_pc_i : s1_pc_i;
    dly = slot0 ? s0_delay_i : s1_delay_i;
    if (idx == 1) ba = pc;
    else if (idx == 6 || idx == 7) ba = slot0 ? s0_maddr_i : s1_maddr_i;
    k0 = slot0 && idx != 8;
    k1 = slot0 || idx != 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4:0] c; logic [31:0] p, b; logic d, k0, k1, bz, t;
    expect_out(c, p, b, d, k0, k1, bz, t);
    chk("exccode", 32'(exccode_o), 32'(c));
    chk("pc", pc_o, p);
    chk("badaddr", badaddr_o, b);
    chk("in_delay", 32'(in_delay_o), 32'(d));
    chk("s0_kill", 32'(s0_kill_o), 32'(k0));
    chk("s1_kill", 32'(s1_kill_o), 32'(k1));
    chk("busy", 32'(busy_o), 32'(bz));
    chk("ip_hw", 32'(ip_hw_o), resetn ? 32'(m_sh[S-1]) : 32'd0);
  endtask

  task automatic model_update();
    logic [4:0] c; logic [31:0] p, b; logic d, k0, k1, bz, t;
    if (!resetn) begin
      m_busy = 0; m_age = 0; m_ack = 0;
      for (int i = 0; i < S; i++) m_sh[i] = '0;
      return;
    end
    expect_out(c, p, b, d, k0, k1, bz, t);
    if (m_busy) begin
      if (m_age + 1 >= D && (m_ack || redirect_ack_i)) m_busy = 0;
      else begin m_age = m_age + 1; m_ack = m_ack | redirect_ack_i; end
    end else if (t) begin
      m_busy = 1; m_age = 0; m_ack = 0;
    end
    for (int i = S - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = ext_int_i;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_slots();
    s0_valid_i = 0; s0_exc_i = 0; s0_pc_i = 0; s0_maddr_i = 0; s0_delay_i = 0;
    s1_valid_i = 0; s1_exc_i = 0; s1_pc_i = 0; s1_maddr_i = 0; s1_delay_i = 0;
  endtask

  task automatic drain_out();
    clear_slots();
    redirect_ack_i = 1;
    for (int i = 0; i < 10 && busy_o; i++) cycle();
    chk("drain_exit", 32'(busy_o), 32'd0);
    redirect_ack_i = 0;
  endtask

  function automatic logic [7:0] rand_flags();
    case ($urandom_range(0, 5))
      0: return 8'(1 << $urandom_range(0, 7));
      1: return 8'($urandom);
      default: return 8'd0;
    endcase
  endfunction

  initial begin
    m_busy = 0; m_age = 0; m_ack = 0;
    for (int i = 0; i < S; i++) m_sh[i] = '0;
    resetn = 0; stall_i = 0; redirect_ack_i = 0; ext_int_i = 0;
    status_i = 0; cause_i = 0;
    clear_slots();
    #1;
    chk("rst_code", 32'(exccode_o), 32'(NONE));
    chk("rst_busy", 32'(busy_o), 32'd0);
    repeat (2) cycle();
    resetn = 1;
    cycle();

    // s0 Ov beats s1 Sys
    s0_valid_i = 1; s0_pc_i = 32'hBFC00100; s0_exc_i = 8'h10;
    s1_valid_i = 1; s1_pc_i = 32'hBFC00104; s1_exc_i = 8'h04;
    #1;
    chk("t2_code", 32'(exccode_o), 32'h0c);
    chk("t2_pc", pc_o, 32'hBFC00100);
    chk("t2_kills", 32'({s0_kill_o, s1_kill_o}), 32'h3);
    cycle();
    clear_slots();
    chk("t2_busy1", 32'(busy_o), 32'd1);
    cycle();
    chk("t2_busy2", 32'(busy_o), 32'd1);
    drain_out();

    // s1 AdES with clean s0
    s0_valid_i = 1; s0_pc_i = 32'h80000010;
    s1_valid_i = 1; s1_exc_i = 8'h40; s1_maddr_i = 32'h80000003; s1_pc_i = 32'h80000014;
    #1;
    chk("t3_code", 32'(exccode_o), 32'h05);
    chk("t3_badaddr", badaddr_o, 32'h80000003);
    chk("t3_kills", 32'({s0_kill_o, s1_kill_o}), 32'h1);
    cycle();
    drain_out();

    // Interrupt masked by EXL, then taken in a delay slot
    status_i = 32'h403; cause_i = 32'h400;
    s0_valid_i = 1; s0_pc_i = 32'h80001000; s0_delay_i = 1;
    #1;
    chk("t4_exl", 32'(exccode_o), 32'(NONE));
    cycle();
    status_i = 32'h401;
    #1;
    chk("t4_code", 32'(exccode_o), 32'h00);
    chk("t4_pc", pc_o, 32'h80001000);
    chk("t4_dly", 32'(in_delay_o), 32'd1);
    cycle();
    status_i = 0; cause_i = 0;
    drain_out();

    // AdEL fetch beats RI; stall holds off Ov
    s0_valid_i = 1; s0_exc_i = 8'h03; s0_pc_i = 32'h80000002;
    #1;
    chk("t5_code", 32'(exccode_o), 32'h04);
    chk("t5_badaddr", badaddr_o, 32'h80000002);
    cycle();
    drain_out();
    s0_valid_i = 1; s0_exc_i = 8'h10; s0_pc_i = 32'h80000020; stall_i = 1;
    #1;
    chk("t5_stall", 32'(exccode_o), 32'(NONE));
    cycle(); cycle();
    stall_i = 0;
    #1;
    chk("t5_unstall", 32'(exccode_o), 32'h0c);
    cycle();
    drain_out();

    // Late ack, Sys during DRAIN ignored
    s0_valid_i = 1; s0_exc_i = 8'h04; s0_pc_i = 32'h80000040;
    cycle();
    repeat (4) cycle();
    chk("t6_hold", 32'(busy_o), 32'd1);
    redirect_ack_i = 1;
    cycle();
    redirect_ack_i = 0;
    chk("t6_exit", 32'(busy_o), 32'd0);
    clear_slots();
    cycle();

    // Interrupt line synchronisation
    ext_int_i = 6'h08;
    cycle();
    chk("t6_ip1", 32'(ip_hw_o[3]), 32'd0);
    cycle();
    chk("t6_ip2", 32'(ip_hw_o[3]), 32'd1);

    // Async reset in the middle of DRAIN
    s0_valid_i = 1; s0_exc_i = 8'h10;
    cycle();
    clear_slots();
    chk("t1_pre", 32'(busy_o), 32'd1);
    resetn = 0;
    #1;
    chk("t1_busy", 32'(busy_o), 32'd0);
    chk("t1_code", 32'(exccode_o), 32'(NONE));
    chk("t1_kills", 32'({s0_kill_o, s1_kill_o}), 32'd0);
    chk("t1_ip", 32'(ip_hw_o), 32'd0);
    cycle();
    resetn = 1;
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      resetn         = ($urandom_range(0, 149) != 0);
      stall_i        = ($urandom_range(0, 4) == 0);
      redirect_ack_i = ($urandom_range(0, 2) == 0);
      s0_valid_i     = ($urandom_range(0, 3) != 0);
      s1_valid_i     = ($urandom_range(0, 3) != 0);
      s0_exc_i       = rand_flags();
      s1_exc_i       = rand_flags();
      s0_pc_i        = $urandom; s1_pc_i = $urandom;
      s0_maddr_i     = $urandom; s1_maddr_i = $urandom;
      s0_delay_i     = 1'($urandom); s1_delay_i = 1'($urandom);
      if ($urandom_range(0, 7) == 0) ext_int_i = 6'($urandom);
      status_i       = {16'($urandom), 8'($urandom), 6'd0,
                        1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
      cause_i        = ($urandom_range(0, 5) == 0) ? {16'd0, 8'($urandom), 8'd0} : 32'd0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
